// File: rtl/fifo_drain.sv
// Drains an upstream FIFO with one-cycle read latency into a valid/ready stream via a 2-entry skid buffer.
// Optional macro FIFO_DRAIN_STATS_EN adds the pop_count handshake counter port.
module fifo_drain #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             fifo_ren,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_data_valid,
   input  logic             fifo_empty,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             protocol_err
`ifdef FIFO_DRAIN_STATS_EN
   ,
   output logic [CNT_W-1:0] pop_count
`endif
);

   if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
      $error("fifo_drain: WIDTH and CNT_W must be at least 1");
   end

   logic [1:0]       occ_q, occ_d;
   logic             valid_q, valid_d;
   logic             inflight_q, inflight_d;
   logic             err_q, err_d;
   logic             rst_seen_q, rst_seen_d;
   logic [WIDTH-1:0] buf0_q, buf0_d;
   logic [WIDTH-1:0] buf1_q, buf1_d;
   logic             pop_s;
   logic             push_s;
   logic [2:0]       level_s;
`ifdef FIFO_DRAIN_STATS_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Next-state logic: read request, buffer update and sticky error.
   always_comb begin
      pop_s      = valid_q & out_ready;
      push_s     = fifo_data_valid & inflight_q;
      // Words that will be held after this cycle if no new read is issued.
      level_s    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
      fifo_ren   = ~rst & en & ~fifo_empty & (level_s <= 3'd1);
      inflight_d = fifo_ren;
      rst_seen_d = 1'b0;
      err_d      = err_q | (fifo_data_valid & ~inflight_q & ~rst_seen_q);
      occ_d      = occ_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      case ({occ_q, push_s, pop_s})
         4'b0010, 4'b0011: begin
            buf0_d = fifo_data;
            occ_d  = 2'd1;
         end
         4'b0101: begin
            occ_d  = 2'd0;
         end
         4'b0110: begin
            buf1_d = fifo_data;
            occ_d  = 2'd2;
         end
         4'b0111: begin
            buf0_d = fifo_data;
         end
         4'b1001: begin
            buf0_d = buf1_q;
            occ_d  = 2'd1;
         end
         4'b1011: begin
            buf0_d = buf1_q;
            buf1_d = fifo_data;
         end
         default: begin
            occ_d  = occ_q;
         end
      endcase
      valid_d    = (occ_d != 2'd0);
`ifdef FIFO_DRAIN_STATS_EN
      cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, pop_s};
`endif
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= 2'd0;
         valid_q    <= 1'b0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
         rst_seen_q <= 1'b1;
`ifdef FIFO_DRAIN_STATS_EN
         cnt_q      <= {CNT_W{1'b0}};
`endif
      end else begin
         occ_q      <= occ_d;
         valid_q    <= valid_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
         rst_seen_q <= rst_seen_d;
`ifdef FIFO_DRAIN_STATS_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   // Buffer payload needs no reset; occupancy decides what is meaningful.
   always_ff @(posedge clk) begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
   end

   assign out_data     = buf0_q;
   assign out_valid    = valid_q;
   assign protocol_err = err_q;
`ifdef FIFO_DRAIN_STATS_EN
   assign pop_count    = cnt_q;
`endif

endmodule
